fa_coef_loader: RTL and testbench

Write-side counterpart to the fA coefficient ROMs: loads the per-channel 16-bit scaling coefficients of a BWN layer from a valid/ready stream into an internal DEPTH x 16 register file. The butterfly/accumulate datapath reads coefficients back through a registered read port. This lets coefficient sets change at run time instead of being hard-wired. Sits between the host/DMA coefficient stream and the layer datapath.

---
 rtl/fa_coef_loader.sv | 103 ++++++++++
 tb/tb_fa_coef_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fa_coef_loader.sv
// rtl/fa_coef_loader.sv - stream loader for the per-channel fA coefficient register file
// Coefficients arrive on a valid/ready stream; the layer datapath reads them back through a registered port.
module fa_coef_loader #(
    parameter int WIDTH_A = 12,
    parameter int DEPTH   = 80,
    parameter int WIDTH_D = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [WIDTH_D-1:0] in_data,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic               loaded,
    output logic [WIDTH_A-1:0] wr_count,
    input  logic               rd_en,
    input  logic [WIDTH_A-1:0] rd_addr,
    output logic [WIDTH_D-1:0] rd_data,
    output logic               rd_valid,
    output logic               rd_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam int                 AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH_A-1:0] LAST    = WIDTH_A'(DEPTH - 1);
    localparam logic [WIDTH_A:0]   DEPTH_X = (WIDTH_A + 1)'(DEPTH);

    state_t               state;
    logic [WIDTH_D-1:0]   mem [DEPTH];
    logic                 hs;
    logic                 rd_oob;
    logic [AW-1:0]        wr_idx;
    logic [AW-1:0]        rd_idx;

    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign hs       = in_valid & in_ready;
    assign rd_oob   = ({1'b0, rd_addr} >= DEPTH_X);
    assign wr_idx   = wr_count[AW-1:0];
    assign rd_idx   = rd_addr[AW-1:0];

    // start is only honoured outside LOAD, so a final handshake always wins over a coincident start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            loaded   <= 1'b0;
            wr_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        wr_count <= '0;
                        loaded   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        wr_count <= wr_count + 1'b1;
                        if (wr_count == LAST) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            loaded <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is intentionally not reset; a partial load survives rst.
    always_ff @(posedge clk) begin
        if (hs) begin
            mem[wr_idx] <= in_data;
        end
    end

    // Non-blocking read of mem gives read-before-write on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en & rd_oob;
            if (rd_en) begin
                rd_data <= rd_oob ? '0 : mem[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_fa_coef_loader.sv
// tb/tb_fa_coef_loader.sv - scoreboard bench for fa_coef_loader
module tb_fa_coef_loader;

    localparam int DEPTH = 80;
    localparam int WA    = 12;
    localparam int WD    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [WD-1:0] in_data = '0;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic          loaded;
    logic [WA-1:0] wr_count;
    logic          rd_en = 1'b0;
    logic [WA-1:0] rd_addr = '0;
    logic [WD-1:0] rd_data;
    logic          rd_valid;
    logic          rd_err;

    fa_coef_loader #(.WIDTH_A(WA), .DEPTH(DEPTH), .WIDTH_D(WD)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .loaded   (loaded),
        .wr_count (wr_count),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_err   (rd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WD-1:0] d;
        logic          e;
        int            at;
    } rd_exp_t;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    logic [WD-1:0] ref_mem [DEPTH];
    rd_exp_t       sbq [$];
    rd_exp_t       exp_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WD-1:0] pat(input int mode, input int i);
        logic [WD-1:0] a;
        case (i)
            0:       a = 16'h001e;
            1:       a = 16'h001f;
            2:       a = 16'h0024;
            default: a = 16'(i * 37 + 5);
        endcase
        if (mode == 1) a = (i == 5) ? 16'h0018 : (a ^ 16'h5a5a);
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_read(input logic [WA-1:0] a);
        rd_exp_t x;
        rd_en   = 1'b1;
        rd_addr = a;
        x.e     = (a >= DEPTH);
        x.d     = x.e ? '0 : ref_mem[a];
        x.at    = cyc + 1;
        sbq.push_back(x);
    endtask

    task automatic do_read(input logic [WA-1:0] a);
        arm_read(a);
        tick();
        rd_en = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rd_valid) begin
            if (sbq.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                exp_rd = sbq.pop_front();
                check("rd_data", rd_data, exp_rd.d);
                check("rd_err", rd_err, exp_rd.e);
                check("rd_latency", cyc, exp_rd.at);
            end
        end else if (rd_err) begin
            check("rd_err_without_valid", rd_err, 0);
        end
    end

    task automatic load(input int n, input int mode, input bit gaps, input bit probe, input bit start_last);
        int d0;
        d0    = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_loaded", loaded, 0);
        check("start_wr_count", wr_count, 0);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 16'hdead;
                tick();
                check("gap_wr_count", wr_count, i);
            end
            in_valid = 1'b1;
            in_data  = pat(mode, i);
            if (probe && (i == 5 || i == 6)) arm_read(5);
            if (i == 10) start = 1'b1;
            if (start_last && i == DEPTH - 1) start = 1'b1;
            check("in_ready", in_ready, 1);
            check("wr_count", wr_count, i);
            ref_mem[i] = pat(mode, i);
            tick();
            start = 1'b0;
            rd_en = 1'b0;
        end
        in_valid = 1'b0;
        if (n == DEPTH) begin
            check("done_pulse", done, 1);
            check("loaded_set", loaded, 1);
            check("final_wr_count", wr_count, DEPTH);
            check("final_in_ready", in_ready, 0);
            check("final_busy", busy, 0);
            tick();
            check("done_cleared", done, 0);
            check("loaded_held", loaded, 1);
            check("done_once", done_cnt - d0, 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_loaded", loaded, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_err", rd_err, 0);
        rst = 1'b0;
        tick();

        load(DEPTH, 0, 1'b0, 1'b0, 1'b0);
        do_read(0);
        do_read(1);
        do_read(2);
        tick();

        in_valid = 1'b1;
        in_data  = 16'hffff;
        repeat (3) begin
            tick();
            check("extra_in_ready", in_ready, 0);
            check("extra_wr_count", wr_count, DEPTH);
        end
        in_valid = 1'b0;
        do_read(79);
        do_read(80);
        do_read(12'd4095);
        tick();

        load(DEPTH, 1, 1'b1, 1'b1, 1'b0);
        for (int a = 0; a < DEPTH; a++) do_read(a[WA-1:0]);
        tick();

        load(DEPTH, 0, 1'b0, 1'b0, 1'b1);
        check("start_last_ignored_busy", busy, 0);
        do_read(5);
        do_read(79);
        tick();

        load(40, 1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_loaded", loaded, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_wr_count", wr_count, 0);
        tick();
        rst = 1'b0;
        tick();
        do_read(39);
        load(DEPTH, 0, 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < DEPTH; a += 7) do_read(a[WA-1:0]);
        do_read(79);

        repeat (3) tick();
        check("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
